afferent_spike_gen: RTL

//  Receiving end of the spindle afferent interface. Takes IEEE-754 single-precision firing rates in pps
//  (Ia_muscle, II_muscle, ...) and converts each into a spike train.

---
 rtl/spindle_pkg.sv | 30 +++
 rtl/afferent_spike_gen_fp_to_ufix.sv | 46 ++++
 rtl/afferent_spike_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/spindle_pkg.sv
// spindle_pkg: constants and types shared by the spindle, afferent and neuron blocks.
//   IEEE_100000 : float bit pattern of 100000.0 pps, the spindle saturation rate
//   FIX_INT_W   : integer bits of the unsigned fixed-point rate
//   FIX_W       : full fixed-point width at the default fraction size
//   st_e        : afferent scan FSM encoding
//   fp_split()  : splits a single-precision float into sign/exponent/mantissa
package spindle_pkg;

    localparam logic [31:0] IEEE_100000 = 32'h47C3_5000;
    localparam int          FIX_INT_W   = 17;
    localparam int          FRAC_DEF    = 8;
    localparam int          FIX_W       = FIX_INT_W + FRAC_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } st_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    function automatic fp32_t fp_split(input logic [31:0] f);
        return fp32_t'(f);
    endfunction

endpackage

// File: rtl/afferent_spike_gen_fp_to_ufix.sv
// fp_to_ufix: combinational IEEE single -> unsigned fixed point (17 integer + FRAC fraction bits).
//   i_f   : float input
//   o_fix : truncated fixed-point result; negative, zero, denormal and NaN give 0,
//           values >= 100000.0 (and +Inf) clamp to 100000 << FRAC
module fp_to_ufix
    import spindle_pkg::*;
#(
    parameter int FRAC = 8,
    parameter int W    = FIX_INT_W + FRAC
) (
    input  logic [31:0]  i_f,
    output logic [W-1:0] o_fix
);

    // Working width must hold the whole 24-bit significand before shifting.
    localparam int          MW   = (W > 24) ? W : 24;
    // Exponent at which the significand's LSB lands on the fixed-point LSB.
    localparam logic [8:0]  BASE = 9'(150 - FRAC);
    localparam logic [W-1:0] SAT = W'(100000) << FRAC;

    fp32_t          w_f;
    logic [8:0]     w_exp;
    logic [MW-1:0]  w_mag;

    always_comb begin
        w_f   = fp_split(i_f);
        w_exp = {1'b0, w_f.exp};
        w_mag = '0;
        o_fix = '0;
        if (w_f.sign || w_f.exp == 8'd0 || (w_f.exp == 8'hFF && w_f.man != '0)) begin
            o_fix = '0;
        end else if (i_f >= IEEE_100000) begin
            // Positive floats order like unsigned integers, so this also catches +Inf.
            o_fix = SAT;
        end else begin
            // Below saturation the value is < 2^17, so a left shift cannot overflow W bits.
            // Right shifts of 24 or more drop everything, covering values < 2^-FRAC.
            if (w_exp >= BASE)
                w_mag = MW'({1'b1, w_f.man}) << (w_exp - BASE);
            else
                w_mag = MW'({1'b1, w_f.man}) >> (BASE - w_exp);
            o_fix = w_mag[W-1:0];
        end
    end

endmodule

// File: rtl/afferent_spike_gen.sv
// afferent_spike_gen: converts per-channel float firing rates (pps) into spike trains.
// One shared phase-accumulator datapath serves the channels round-robin, one per cycle,
// after each tick; spikes of the whole scan are presented together in the EMIT cycle.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_tick           : one-cycle strobe, advances model time by 1/STEP_HZ s
//   i_rate_in        : N_CH packed floats, channel k at [32k+31:32k]
//   o_busy           : high during the scan
//   o_spike          : per-channel fire bits, valid only with o_spike_valid
//   o_spike_valid    : one-cycle strobe after the scan
//   o_tick_overrun   : sticky, a tick arrived while busy (cleared by reset only)
module afferent_spike_gen
    import spindle_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int STEP_HZ = 1024,
    parameter int FRAC    = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [32*N_CH-1:0] i_rate_in,
    output logic               o_busy,
    output logic [N_CH-1:0]    o_spike,
    output logic               o_spike_valid,
    output logic               o_tick_overrun
);

    localparam int               W     = FIX_INT_W + FRAC;
    localparam int               ACC_W = 26;
    localparam int               CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [ACC_W-1:0] THR   = ACC_W'(STEP_HZ) << FRAC;

    st_e               r_state, w_next;
    logic [CH_W-1:0]   r_ch;
    logic [ACC_W-1:0]  r_phase [N_CH];
    logic [N_CH-1:0]   r_spike;
    logic              r_ovr;

    logic [31:0]       w_rate;
    logic [W-1:0]      w_inc;
    logic [ACC_W-1:0]  w_acc, w_sub, w_phase_nxt;
    logic              w_fire, w_last;

    assign w_rate = i_rate_in[{r_ch, 5'd0} +: 32];

    fp_to_ufix #(.FRAC(FRAC)) u_cvt (
        .i_f   (w_rate),
        .o_fix (w_inc)
    );

    // Shared accumulator: one phase update per SCAN cycle for channel r_ch.
    // The wrapped phase is clamped below THR so a saturated rate fires once per tick.
    always_comb begin
        w_acc       = r_phase[r_ch] + ACC_W'(w_inc);
        w_fire      = (w_acc >= THR);
        w_sub       = w_acc - THR;
        w_phase_nxt = w_acc;
        if (w_fire)
            w_phase_nxt = (w_sub > THR - 1'b1) ? THR - 1'b1 : w_sub;
        w_last      = (r_ch == CH_W'(N_CH - 1));
    end

    always_comb begin
        w_next         = r_state;
        o_busy         = 1'b0;
        o_spike_valid  = 1'b0;
        o_spike        = '0;
        unique case (r_state)
            ST_IDLE: if (i_tick) w_next = ST_SCAN;
            ST_SCAN: begin
                o_busy = 1'b1;
                if (w_last) w_next = ST_EMIT;
            end
            ST_EMIT: begin
                o_spike_valid = 1'b1;
                o_spike       = r_spike;
                // A tick here starts the next scan without an idle gap.
                w_next        = i_tick ? ST_SCAN : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_tick_overrun = r_ovr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_spike <= '0;
            r_ovr   <= 1'b0;
            for (int k = 0; k < N_CH; k++) r_phase[k] <= '0;
        end else begin
            r_state <= w_next;
            if (i_tick && r_state == ST_SCAN) r_ovr <= 1'b1;
            if (r_state == ST_SCAN) begin
                r_phase[r_ch] <= w_phase_nxt;
                r_spike[r_ch] <= w_fire;
                r_ch          <= w_last ? '0 : r_ch + 1'b1;
            end else begin
                r_ch <= '0;
            end
        end
    end

endmodule
